seq_detect_ctrl: RTL and testbench

Run-control block for the serial sequence-detection datapath. It latches a programmable pattern of 1..MAX_LEN bits and a detection mode, overlapping (repeat) or non-overlapping. It then gates a valid-qualified bitstream through the matcher, counts matches and stops once a programmed match target is reached. It sits between the host config/control interface and the serial input, and replaces fixed-pattern detectors where run/stop sequencing is needed.

---
 rtl/seq_detect_ctrl_if.sv | 35 +++
 rtl/seq_detect_ctrl.sv | 126 ++++++++++++
 tb/tb_seq_detect_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_ctrl_if.sv
// Host config/control and serial-data bundle for the sequence-detect run controller.
interface seq_detect_ctrl_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_repeat;
  logic [CNT_W-1:0]   cfg_target;
  logic               start;
  logic               abort;
  logic               data_valid;
  logic               data_in;
  logic               busy;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               done;
  logic               cfg_err;

  // Host / stimulus side
  modport master (
    output cfg_pattern, cfg_len, cfg_repeat, cfg_target,
    output start, abort, data_valid, data_in,
    input  busy, match, match_cnt, done, cfg_err
  );

  // Controller side
  modport slave (
    input  cfg_pattern, cfg_len, cfg_repeat, cfg_target,
    input  start, abort, data_valid, data_in,
    output busy, match, match_cnt, done, cfg_err
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Run controller for serial pattern detection: latches a pattern at start,
// matches a valid-qualified bitstream, counts matches and stops at a target.
module seq_detect_ctrl #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8
) (
  input logic          clk,
  input logic          rst,
  seq_detect_ctrl_if.slave bus
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_repeat;
  logic [CNT_W-1:0]   r_target;
  logic [MAX_LEN-1:0] r_window;
  logic [LEN_W-1:0]   r_fill;
  logic               r_busy;
  logic               r_match;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;
  logic               r_cfg_err;

  logic [MAX_LEN-1:0] w_window_new;
  logic [LEN_W-1:0]   w_fill_new;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_hit;
  logic               w_cfg_ok;
  logic [CNT_W-1:0]   w_cnt_inc;

  // Window/fill as they would be after shifting in the current bit
  assign w_window_new = {r_window[MAX_LEN-2:0], bus.data_in};
  assign w_fill_new   = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
  assign w_cnt_inc    = r_cnt + CNT_W'(1);

  // Start is accepted only with a legal length and a non-zero target
  assign w_cfg_ok = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN)) &&
                    (bus.cfg_target != '0);

  // Compare mask covering the low r_len bits of the window
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (LEN_W'(i) < r_len);
    end
  end

  // Match on the post-shift window once enough fresh bits have arrived
  assign w_hit = (w_fill_new >= r_len) && (((w_window_new ^ r_pattern) & w_mask) == '0);

  // Run-control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pattern <= '0;
      r_len     <= '0;
      r_repeat  <= 1'b0;
      r_target  <= '0;
      r_window  <= '0;
      r_fill    <= '0;
      r_busy    <= 1'b0;
      r_match   <= 1'b0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_match   <= 1'b0;
      r_cfg_err <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            if (!w_cfg_ok) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_pattern <= bus.cfg_pattern;
              r_len     <= bus.cfg_len;
              r_repeat  <= bus.cfg_repeat;
              r_target  <= bus.cfg_target;
              r_window  <= '0;
              r_fill    <= '0;
              r_cnt     <= '0;
              r_done    <= 1'b0;
              r_busy    <= 1'b1;
              r_state   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // abort wins over any bit sampled in the same cycle
          if (bus.abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (bus.data_valid) begin
            r_window <= w_window_new;
            if (w_hit) begin
              r_match <= 1'b1;
              r_cnt   <= w_cnt_inc;
              r_fill  <= r_repeat ? w_fill_new : '0;
              if (w_cnt_inc == r_target) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_fill <= w_fill_new;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.match     = r_match;
  assign bus.match_cnt = r_cnt;
  assign bus.done      = r_done;
  assign bus.cfg_err   = r_cfg_err;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: directed plan scenarios plus randomized runs,
// every cycle compared against a queue-based reference model.
module tb_seq_detect_ctrl;
  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

  logic clk;
  logic rst;

  seq_detect_ctrl_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks;
  int n_fail;
  int n_pulses;

  // Reference model: received bits since the last reset of the fill
  bit                 m_busy;
  bit                 m_done;
  bit                 m_match;
  bit                 m_err;
  int                 m_cnt;
  int                 m_len;
  int                 m_tgt;
  bit                 m_rep;
  logic [MAX_LEN-1:0] m_pat;
  bit                 hist[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit tail_match();
    int n = hist.size();
    if (n < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      if (hist[n-1-k] != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_reset();
    m_busy = 1'b0; m_done = 1'b0; m_match = 1'b0; m_err = 1'b0; m_cnt = 0;
    hist.delete();
  endfunction

  function automatic void model_edge(input bit st, input bit ab, input bit dv, input bit di);
    int len = int'(bus.cfg_len);
    int tgt = int'(bus.cfg_target);
    m_match = 1'b0;
    m_err   = 1'b0;
    if (!m_busy) begin
      if (st) begin
        if (len == 0 || len > MAX_LEN || tgt == 0) begin
          m_err = 1'b1;
        end else begin
          m_pat = bus.cfg_pattern; m_len = len; m_rep = bus.cfg_repeat; m_tgt = tgt;
          m_cnt = 0; m_done = 1'b0; m_busy = 1'b1;
          hist.delete();
        end
      end
    end else if (ab) begin
      m_busy = 1'b0;
    end else if (dv) begin
      hist.push_back(di);
      if (hist.size() > MAX_LEN) void'(hist.pop_front());
      if (tail_match()) begin
        m_match = 1'b1;
        m_cnt++;
        if (!m_rep) hist.delete();
        if (m_cnt == m_tgt) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  endfunction

  task automatic check_outputs();
    chk("busy",      32'(bus.busy),      32'(m_busy));
    chk("match",     32'(bus.match),     32'(m_match));
    chk("match_cnt", 32'(bus.match_cnt), 32'(m_cnt));
    chk("done",      32'(bus.done),      32'(m_done));
    chk("cfg_err",   32'(bus.cfg_err),   32'(m_err));
  endtask

  task automatic cyc(input bit st, input bit ab, input bit dv, input bit di);
    bus.start = st; bus.abort = ab; bus.data_valid = dv; bus.data_in = di;
    @(posedge clk);
    model_edge(st, ab, dv, di);
    #1;
    check_outputs();
    if (bus.match === 1'b1) n_pulses++;
    bus.start = 1'b0; bus.abort = 1'b0; bus.data_valid = 1'b0;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    check_outputs();
    rst = 1'b0;
  endtask

  task automatic set_cfg(input logic [MAX_LEN-1:0] pat, input int len, input bit rep, input int tgt);
    bus.cfg_pattern = pat;
    bus.cfg_len     = LEN_W'(len);
    bus.cfg_repeat  = rep;
    bus.cfg_target  = CNT_W'(tgt);
  endtask

  task automatic send(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      cyc(1'b0, 1'b0, 1'b1, s[i] == 8'h31);
      if (gaps) cyc(1'b0, 1'b0, 1'b0, 1'($urandom));
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; n_pulses = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.data_valid = 1'b0; bus.data_in = 1'b0;
    set_cfg('0, 0, 1'b0, 0);
    model_reset();
    do_rst();

    // Overlapping detection of 10010
    set_cfg(8'b0001_0010, 5, 1'b1, 255);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    n_pulses = 0;
    send("10010010010", 1'b0);
    chk("rep_pulses", 32'(n_pulses), 32'd3);
    chk("rep_cnt", 32'(bus.match_cnt), 32'd3);
    chk("rep_busy", 32'(bus.busy), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("abort_keeps_cnt", 32'(bus.match_cnt), 32'd3);

    // Non-overlapping detection, same stream
    set_cfg(8'b0001_0010, 5, 1'b0, 255);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    n_pulses = 0;
    send("10010010010", 1'b0);
    chk("norep_pulses", 32'(n_pulses), 32'd2);
    chk("norep_cnt", 32'(bus.match_cnt), 32'd2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);

    // Target reached: stop in DONE, later bits ignored
    set_cfg(8'b0000_0101, 3, 1'b1, 2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send("10101", 1'b0);
    chk("tgt_match", 32'(bus.match), 32'd1);
    chk("tgt_done", 32'(bus.done), 32'd1);
    chk("tgt_busy", 32'(bus.busy), 32'd0);
    chk("tgt_cnt", 32'(bus.match_cnt), 32'd2);
    n_pulses = 0;
    send("101", 1'b0);
    chk("after_done_pulses", 32'(n_pulses), 32'd0);
    // Rejected start in DONE leaves done held
    set_cfg(8'b0000_0101, 0, 1'b1, 2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rej_err", 32'(bus.cfg_err), 32'd1);
    chk("rej_done_held", 32'(bus.done), 32'd1);

    // Valid gaps neither break nor create matches
    set_cfg(8'b0001_0010, 5, 1'b1, 255);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    n_pulses = 0;
    send("10010", 1'b1);
    chk("gap_pulses", 32'(n_pulses), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);

    // Illegal configurations
    set_cfg(8'b0000_0101, 0, 1'b1, 3);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("len0_err", 32'(bus.cfg_err), 32'd1);
    chk("len0_busy", 32'(bus.busy), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("err_one_cycle", 32'(bus.cfg_err), 32'd0);
    set_cfg(8'b0000_0101, 3, 1'b1, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("tgt0_err", 32'(bus.cfg_err), 32'd1);
    set_cfg(8'b0000_0101, 9, 1'b1, 3);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("len9_err", 32'(bus.cfg_err), 32'd1);
    chk("len9_busy", 32'(bus.busy), 32'd0);

    // Abort on the completing bit beats the match
    set_cfg(8'b0000_0101, 3, 1'b1, 5);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send("10", 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("abort_match", 32'(bus.match), 32'd0);
    chk("abort_cnt", 32'(bus.match_cnt), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);

    // Synchronous reset mid-run
    set_cfg(8'b0000_0001, 1, 1'b0, 9);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send("1101", 1'b0);
    do_rst();
    chk("rst_cnt", 32'(bus.match_cnt), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);

    // Randomized runs, including config churn during RUN
    for (int run = 0; run < 40; run++) begin
      set_cfg(MAX_LEN'($urandom), int'($urandom_range(0, 9)), 1'($urandom),
              ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6)));
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 7) == 0)
          set_cfg(MAX_LEN'($urandom), int'($urandom_range(0, 9)), 1'($urandom),
                  int'($urandom_range(0, 6)));
        if ($urandom_range(0, 300) == 0) begin
          do_rst();
        end else begin
          cyc($urandom_range(0, 15) == 0, $urandom_range(0, 40) == 0,
              $urandom_range(0, 3) != 0, 1'($urandom));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
